// File: rtl/stream_select_mux.sv
// NCH:1 valid/ready stream mux; fixed select, plus round-robin when STREAM_SELECT_MUX_RR_EN is defined.
// Latency: 1 cycle. A word accepted at edge n is on OutData/OutValid right after edge n.
// Backpressure: one-deep output register. All InReady drop to 0 while OutValid & ~OutReady.
module stream_select_mux #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NCH*WIDTH-1:0] InData,
    input  logic [NCH-1:0]       InValid,
    output logic [NCH-1:0]       InReady,
    input  logic [SELW-1:0]      Sel,
    input  logic                 Mode,
    output logic [WIDTH-1:0]     OutData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [SELW-1:0]      Grant,
    output logic [7:0]           XferCount
);
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_grant;
    logic [7:0]       r_xfer_cnt;

    logic             w_load_en;
    logic             w_ch_ok;
    logic             w_xfer;
    logic [SELW-1:0]  w_ch;
    logic [WIDTH-1:0] w_data;

    assign w_load_en = ~r_out_valid | OutReady;

`ifdef STREAM_SELECT_MUX_RR_EN
    logic [SELW-1:0] r_ptr;
    logic            w_rr_ok;
    logic [SELW-1:0] w_rr_ch;

    // Winner is the valid channel at the smallest distance past r_ptr.
    always_comb begin
        int dist;
        int best;
        dist    = 0;
        best    = NCH;
        w_rr_ok = 1'b0;
        w_rr_ch = '0;
        for (int k = 0; k < NCH; k++) begin
            dist = (k + NCH - 1 - int'(r_ptr)) % NCH;
            if (InValid[k] && (dist < best)) begin
                best    = dist;
                w_rr_ok = 1'b1;
                w_rr_ch = SELW'(k);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ptr <= SELW'(NCH - 1);
        end else if (w_xfer) begin
            r_ptr <= w_ch;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = Mode;
`endif

    always_comb begin
        w_ch    = Sel;
        w_ch_ok = (int'(Sel) < NCH);
`ifdef STREAM_SELECT_MUX_RR_EN
        if (Mode) begin
            w_ch    = w_rr_ch;
            w_ch_ok = w_rr_ok;
        end
`endif
    end

    // InReady is one-hot or zero, so it doubles as the data-select mask.
    always_comb begin
        InReady = '0;
        w_data  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_load_en && w_ch_ok && (int'(w_ch) == k)) begin
                InReady[k] = 1'b1;
            end
            if (InReady[k]) begin
                w_data = w_data | InData[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = |(InReady & InValid);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_grant     <= '0;
            r_xfer_cnt  <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_data;
            r_out_valid <= 1'b1;
            r_grant     <= w_ch;
            r_xfer_cnt  <= r_xfer_cnt + 8'd1;
        end else if (OutReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OutData   = r_out_data;
    assign OutValid  = r_out_valid;
    assign Grant     = r_grant;
    assign XferCount = r_xfer_cnt;

endmodule

// File: tb/tb_stream_select_mux.sv
// Randomised and directed scoreboard bench for stream_select_mux (4x4 build plus a 5-channel instance).
module tb_stream_select_mux;
    localparam int WIDTH = 4;
    localparam int NCH   = 4;
    localparam int SELW  = 2;
`ifdef STREAM_SELECT_MUX_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] data;
        logic [1:0] grant;
        logic [7:0] cnt;
    } exp_t;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b1;
    logic [NCH*WIDTH-1:0] InData = '0;
    logic [NCH-1:0]       InValid = '0;
    logic [NCH-1:0]       InReady;
    logic [SELW-1:0]      Sel = '0;
    logic                 Mode = 1'b0;
    logic [WIDTH-1:0]     OutData;
    logic                 OutValid;
    logic                 OutReady = 1'b0;
    logic [SELW-1:0]      Grant;
    logic [7:0]           XferCount;

    logic [19:0] InData5 = 20'h43210;
    logic [4:0]  InValid5 = 5'h1F;
    logic [4:0]  InReady5;
    logic [2:0]  Sel5 = 3'd0;
    logic [3:0]  OutData5;
    logic        OutValid5;
    logic [2:0]  Grant5;
    logic [7:0]  XferCount5;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   m_ptr = NCH - 1;
    bit   m_valid = 1'b0;
    int   m_cnt = 0;
    logic [3:0] m_held = '0;

    stream_select_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .Clk(Clk), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady),
        .Sel(Sel), .Mode(Mode), .OutData(OutData), .OutValid(OutValid),
        .OutReady(OutReady), .Grant(Grant), .XferCount(XferCount)
    );

    stream_select_mux #(.WIDTH(4), .NCH(5), .SELW(3)) dut5 (
        .Clk(Clk), .Rst(Rst), .InData(InData5), .InValid(InValid5), .InReady(InReady5),
        .Sel(Sel5), .Mode(1'b0), .OutData(OutData5), .OutValid(OutValid5),
        .OutReady(1'b1), .Grant(Grant5), .XferCount(XferCount5)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference choice: explicit select, or first valid channel after the last grant.
    function automatic int pick(input bit mode, input int sel, input logic [3:0] v);
        if (RR_EN && mode) begin
            for (int j = 1; j <= NCH; j++) begin
                if (v[(m_ptr + j) % NCH]) return (m_ptr + j) % NCH;
            end
            return -1;
        end
        return (sel < NCH) ? sel : -1;
    endfunction

    task automatic step(input logic [3:0] v, input logic [15:0] d, input logic [1:0] sel,
                        input logic mode, input logic ordy);
        int         ch;
        bit         le;
        logic [3:0] exp_rdy;
        exp_t       e;
        @(posedge Clk);
        #1;
        chk("out_valid", {31'd0, OutValid}, {31'd0, m_valid});
        InValid  = v;
        InData   = d;
        Sel      = sel;
        Mode     = mode;
        OutReady = ordy;
        #1;
        le      = !m_valid || ordy;
        ch      = pick(mode, int'(sel), v);
        exp_rdy = (le && ch >= 0) ? 4'(1 << ch) : 4'b0000;
        chk("in_ready", {28'd0, InReady}, {28'd0, exp_rdy});
        if (m_valid && !ordy) chk("held_data", {28'd0, OutData}, {28'd0, m_held});
        if (le && ch >= 0 && v[ch]) begin
            m_cnt   = (m_cnt + 1) % 256;
            e.data  = d[ch*4 +: 4];
            e.grant = 2'(ch);
            e.cnt   = 8'(m_cnt);
            sb.push_back(e);
            m_held  = e.data;
            m_valid = 1'b1;
            m_ptr   = ch;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #3;
        Rst      = 1'b1;
        InValid  = '0;
        OutReady = 1'b0;
        #1;
        chk("rst_data", {28'd0, OutData}, 32'd0);
        chk("rst_valid", {31'd0, OutValid}, 32'd0);
        chk("rst_grant", {30'd0, Grant}, 32'd0);
        chk("rst_cnt", {24'd0, XferCount}, 32'd0);
        sb.delete();
        m_valid = 1'b0;
        m_cnt   = 0;
        m_ptr   = NCH - 1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Rst && OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: output word %0h with no expected entry", OutData);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {28'd0, OutData}, {28'd0, e.data});
                    chk("out_grant", {30'd0, Grant}, {30'd0, e.grant});
                    chk("out_cnt", {24'd0, XferCount}, {24'd0, e.cnt});
                end
            end
        end
    end

    initial begin
        logic [15:0] rd;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Fixed select of channel 2
        step(4'b0100, 16'h0A00, 2'd2, 1'b0, 1'b1);
        step(4'b0000, 16'h0000, 2'd0, 1'b0, 1'b0);
        chk("fix_data", {28'd0, OutData}, 32'hA);
        chk("fix_grant", {30'd0, Grant}, 32'd2);
        chk("fix_cnt", {24'd0, XferCount}, 32'd1);

        // Stall 3 cycles with channel 1 waiting, then release
        repeat (3) step(4'b0010, 16'h00B0, 2'd1, 1'b0, 1'b0);
        step(4'b0010, 16'h00B0, 2'd1, 1'b0, 1'b1);
        step(4'b0000, 16'h0000, 2'd0, 1'b0, 1'b1);
        chk("bp_grant", {30'd0, Grant}, 32'd1);
        chk("bp_data", {28'd0, OutData}, 32'hB);

        // Out-of-range select on the 5-channel instance
        Sel5 = 3'd5;
        #1;
        chk("sel_oob", {27'd0, InReady5}, 32'd0);
        Sel5 = 3'd4;
        #1;
        chk("sel_ch4", {27'd0, InReady5}, 32'h10);

        for (int i = 0; i < 400; i++) begin
            rd = 16'($urandom);
            step(4'($urandom), rd, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        do_reset();
        for (int i = 0; i < 8; i++) step(4'hF, 16'($urandom), 2'($urandom), 1'b1, 1'b1);
        step(4'h0, 16'h0000, 2'd0, 1'b1, 1'b1);
        chk("fair_cnt", {24'd0, XferCount}, 32'd8);

        step(4'b1000, 16'($urandom), 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1001, 16'($urandom), 2'd3, 1'b1, 1'b1);

        do_reset();
        for (int i = 0; i < 10; i++) step(4'hF, 16'($urandom), 2'd1, 1'b1, 1'b1);

        do_reset();
        for (int i = 0; i < 256; i++) step(4'hF, 16'($urandom), 2'($urandom), 1'b0, 1'b1);
        step(4'h0, 16'h0000, 2'd0, 1'b0, 1'b1);
        chk("wrap_cnt", {24'd0, XferCount}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            step(4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
        end
        do_reset();
        step(4'h0, 16'h0000, 2'd0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
